seq_detector_prog: RTL

Programmable, parametrised serial sequence detector: the generalised successor of the fixed 4-bit Moore pattern detectors in this codebase. It compares a 1-bit serial stream against an N-bit pattern that is loadable at runtime. It supports overlapping and non-overlapping detection, a per-bit valid qualifier, and a saturating match counter. It sits between the serial input sampler and the control/status logic. Its output is a registered, Moore-style match pulse.

---
 rtl/seq_detector_prog_if.sv | 29 ++
 rtl/seq_detector_prog.sv | 74 +++++++
 2 files changed

// File: rtl/seq_detector_prog_if.sv
// Bundles the serial input, the control strobes and the status outputs of seq_detector_prog.
// in_valid is a qualifier: in is consumed on any rising edge with in_valid=1 and load=0.
// There is no ready signal, so the detector never back-pressures.
interface seq_detector_prog_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  logic                     in;
  logic                     in_valid;
  logic                     overlap;
  logic                     load;
  logic [N-1:0]             load_pattern;
  logic                     clear_count;
  logic                     q;
  logic [CNT_W-1:0]         match_count;
  logic [$clog2(N+1)-1:0]   fill;
  logic                     cnt_sat;
  logic [N-1:0]             dbg_pat;

  modport master (
    output in, in_valid, overlap, load, load_pattern, clear_count,
    input  q, match_count, fill, cnt_sat, dbg_pat
  );

  modport slave (
    input  in, in_valid, overlap, load, load_pattern, clear_count,
    output q, match_count, fill, cnt_sat, dbg_pat
  );
endinterface

// File: rtl/seq_detector_prog.sv
// Programmable N-bit serial pattern detector with a registered match pulse.
// It supports overlap and non-overlap modes and keeps a saturating match counter.
module seq_detector_prog #(
  parameter int           N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1001,
  parameter int           CNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  seq_detector_prog_if.slave  bus
);
  localparam int             FW        = $clog2(N+1);
  localparam logic [FW-1:0]  FILL_FULL = FW'(N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N-1:0]     r_hist;
  logic [FW-1:0]    r_fill;
  logic [N-1:0]     r_pat;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic             r_q;

  logic             w_bit;
  logic [N-1:0]     w_hist_n;
  logic [FW-1:0]    w_fill_n;
  logic             w_match;

  assign w_bit    = bus.in_valid && !bus.load;
  assign w_hist_n = {r_hist[N-2:0], bus.in};
  assign w_fill_n = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + 1'b1;
  // The fill gate stops stale zeros after reset or load from matching an all-zero pattern.
  assign w_match  = w_bit && (w_fill_n == FILL_FULL) && (w_hist_n == r_pat);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat  <= PATTERN;
      r_hist <= '0;
      r_fill <= '0;
      r_q    <= 1'b0;
      r_cnt  <= '0;
      r_sat  <= 1'b0;
    end else begin
      r_q <= 1'b0;
      if (bus.load) begin
        r_pat  <= bus.load_pattern;
        r_hist <= '0;
        r_fill <= '0;
      end else if (bus.in_valid) begin
        r_hist <= w_hist_n;
        if (w_match) begin
          r_q    <= 1'b1;
          r_fill <= bus.overlap ? FILL_FULL : '0;
        end else begin
          r_fill <= w_fill_n;
        end
      end

      // Clear beats a same-cycle increment; q above still pulses.
      if (bus.clear_count) begin
        r_cnt <= '0;
        r_sat <= 1'b0;
      end else if (w_match && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CNT_MAX - 1'b1) r_sat <= 1'b1;
      end
    end
  end

  assign bus.q           = r_q;
  assign bus.match_count = r_cnt;
  assign bus.fill        = r_fill;
  assign bus.cnt_sat     = r_sat;
  assign bus.dbg_pat     = r_pat;
endmodule
